simon_round_ctrl: RTL and testbench
===================================

# simon_round_ctrl

Sequencing controller for the Simon block-cipher datapath inside `simon`. It accepts a key and plaintext/ciphertext blocks through valid/ready handshakes and runs key expansion into the datapath's round-key store. It then steps the datapath through every round, supplying the round index and key-schedule `z` constant bit, and holds the result until it is consumed downstream. The controller holds no data, only control state, so it can be verified without the datapath.

## Interface
Parameters:
- `ROUNDS`, 44: rounds per block (Simon 64/128); legal range 8..72.
- `RIDX_W`, 7: round-index width; must satisfy `2**RIDX_W >= ROUNDS`.
- `Z_SEQ`, Simon z3 constant: 62-bit vector; element 0 in bit 0.

Ports (one clock; reset is synchronous and active-high):
- `clk_simon_cfg`  in  1  sole clock; all state updates on its rising edge.
- `rst_simon_cfg`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  key present on the datapath key bus.
- `key_ready`  out  1  controller will accept a key.
- `blk_in_valid`  in  1  input block present.
- `blk_in_ready`  out  1  controller will accept a block.
- `blk_out_valid`  out  1  datapath result valid.
- `blk_out_ready`  in  1  downstream accepts the result.
- `blk_decrypt`  in  1  decrypt request, sampled on the block handshake. Present only under the macro.
- `dp_key_load`  out  1  datapath loads the 4 key words as round keys 0..3.
- `dp_ks_en`  out  1  datapath computes and stores round key `dp_round_idx`.
- `dp_blk_load`  out  1  datapath loads the input block.
- `dp_round_en`  out  1  datapath applies one round using round key `dp_round_idx`.
- `dp_round_idx`  out  RIDX_W  round / key index.
- `dp_z_bit`  out  1  `Z_SEQ[z_ptr]`, valid while `dp_ks_en` is high.
- `key_loaded`  out  1  expanded key available.
- `busy`  out  1  high in KEXP, RUN and DONE.

## Operation
- States: NOKEY, KEXP, READY, RUN, DONE. Reset enters NOKEY.
- Reset values:
  - All outputs are 0, except `key_ready` = 1, which is decoded from NOKEY.
  - Counters `ridx` and `z_ptr` reset to 0.
- `key_ready` is high in NOKEY and READY.
- `blk_in_ready` is `(state==READY) && !key_valid`. A key therefore takes priority over a block presented in the same cycle.
- `dp_key_load` = `key_valid && key_ready`, combinational.
- Key handshake:
  - Next state is KEXP, with `ridx` = 4 and `z_ptr` = 0.
  - `key_loaded` drops to 0.
- KEXP:
  - `dp_ks_en` = 1 and `dp_round_idx` = `ridx`.
  - Each cycle, `ridx` increments and `z_ptr` increments, wrapping 61 -> 0.
  - After the cycle with `ridx == ROUNDS-1`, next state is READY and `key_loaded` = 1.
- Block handshake (`dp_blk_load` = `blk_in_valid && blk_in_ready`):
  - Next state is RUN.
  - `ridx` is set to 0 for encrypt, or ROUNDS-1 for decrypt.
- RUN:
  - `dp_round_en` = 1 and `dp_round_idx` = `ridx`.
  - `ridx` increments for encrypt, decrements for decrypt.
  - After the final round (index ROUNDS-1 for encrypt, 0 for decrypt), next state is DONE.
- DONE:
  - `blk_out_valid` = 1, held stable until `blk_out_ready`.
  - On the handshake, next state is READY.
  - `key_ready` and `blk_in_ready` are 0.
- All `dp_*` strobes are 0 outside their states, and `dp_round_idx` reads 0 when neither `dp_ks_en` nor `dp_round_en` is high.
- Index arithmetic is unsigned, RIDX_W bits. The terminal compare is done before the update, so `ridx` never wraps.

## Timing
- Key handshake in cycle T:
  - KEXP occupies T+1..T+ROUNDS-4.
  - READY from T+ROUNDS-3.
- Block handshake in cycle B:
  - RUN occupies B+1..B+ROUNDS.
  - `blk_out_valid` rises at B+ROUNDS+1.
- Out handshake in cycle D: READY and `blk_in_ready` at D+1. Back-to-back blocks therefore run every ROUNDS+2 cycles.
- Reset asserted in any state: NOKEY at the next edge, `key_loaded` = 0, no further strobes. An in-flight block is discarded.
- `key_valid` in KEXP/RUN/DONE is ignored (`key_ready` = 0).

## Configuration
- `SIMON_DECRYPT_EN` defined:
  - The `blk_decrypt` port exists.
  - A decrypt block runs round indices ROUNDS-1 down to 0.
- `SIMON_DECRYPT_EN` undefined:
  - The `blk_decrypt` port is absent.
  - Every block runs encrypt order, 0 up to ROUNDS-1.

## Test plan
- Reset, then key handshake at T: `dp_key_load` = 1 at T; `dp_ks_en` for 40 cycles with idx 4..43 and `dp_z_bit` = `Z_SEQ[0..39]`; `key_loaded` = 1 at T+41.
- Encrypt block at B: `dp_round_en` for 44 cycles with idx 0..43; `blk_out_valid` at B+45.
- Hold `blk_out_ready` = 0 for 10 cycles in DONE: `blk_out_valid` stays 1, `blk_in_ready` = 0, no strobes. Release: READY the next cycle.
- `key_valid` and `blk_in_valid` both high in READY: `blk_in_ready` = 0, the key is taken, KEXP starts, and the block waits.
- Decrypt (macro on): idx 43 down to 0 over 44 cycles. With ROUNDS=72: `z_ptr` wraps 61 -> 0 at KEXP idx 66, so `dp_z_bit` = `Z_SEQ[0]`.
- Assert reset mid-RUN at round 20: NOKEY next cycle, `key_loaded` = 0, `blk_in_ready` = 0 until a new key has been expanded.

Source files
------------

// File: rtl/simon_round_ctrl.sv
// Control-only sequencer for the Simon datapath: key expansion, round stepping and result hold.
// Defining SIMON_DECRYPT_EN adds the blk_decrypt port and descending round order for decrypt blocks.
module simon_round_ctrl #(
  parameter int ROUNDS = 44,
  parameter int RIDX_W = 7,
  parameter logic [61:0] Z_SEQ =
    62'b11_1100001011_0011100101_0001001000_0001111010_0110001101_0111011011
) (
  input  logic              clk_simon_cfg,
  input  logic              rst_simon_cfg,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              blk_in_valid,
  output logic              blk_in_ready,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
`ifdef SIMON_DECRYPT_EN
  input  logic              blk_decrypt,
`endif
  output logic              dp_key_load,
  output logic              dp_ks_en,
  output logic              dp_blk_load,
  output logic              dp_round_en,
  output logic [RIDX_W-1:0] dp_round_idx,
  output logic              dp_z_bit,
  output logic              key_loaded,
  output logic              busy
);

  typedef enum logic [2:0] {NOKEY, KEXP, READY, RUN, DONE} state_t;

  localparam logic [RIDX_W-1:0] IDX_LAST     = RIDX_W'(ROUNDS - 1);
  localparam logic [RIDX_W-1:0] IDX_KS_FIRST = RIDX_W'(4);

  state_t            state, state_nxt;
  logic [RIDX_W-1:0] ridx, ridx_nxt;
  logic [5:0]        z_ptr, z_ptr_nxt;
  logic              dec, dec_nxt;
  logic              blk_dec_req;

`ifdef SIMON_DECRYPT_EN
  assign blk_dec_req = blk_decrypt;
`else
  assign blk_dec_req = 1'b0;
`endif

  always_ff @(posedge clk_simon_cfg) begin
    if (rst_simon_cfg) begin
      state <= NOKEY;
      ridx  <= '0;
      z_ptr <= '0;
      dec   <= 1'b0;
    end else begin
      state <= state_nxt;
      ridx  <= ridx_nxt;
      z_ptr <= z_ptr_nxt;
      dec   <= dec_nxt;
    end
  end

  // A key offered in READY wins over a block offered in the same cycle.
  always_comb begin
    state_nxt     = state;
    ridx_nxt      = ridx;
    z_ptr_nxt     = z_ptr;
    dec_nxt       = dec;
    key_ready     = (state == NOKEY) || (state == READY);
    blk_in_ready  = (state == READY) && !key_valid;
    blk_out_valid = (state == DONE);
    dp_key_load   = key_valid && key_ready;
    dp_blk_load   = blk_in_valid && blk_in_ready;
    dp_ks_en      = 1'b0;
    dp_round_en   = 1'b0;
    dp_round_idx  = '0;
    dp_z_bit      = 1'b0;
    key_loaded    = (state == READY) || (state == RUN) || (state == DONE);
    busy          = (state == KEXP) || (state == RUN) || (state == DONE);

    case (state)
      NOKEY, READY: begin
        if (dp_key_load) begin
          state_nxt = KEXP;
          ridx_nxt  = IDX_KS_FIRST;
          z_ptr_nxt = '0;
        end else if (dp_blk_load) begin
          state_nxt = RUN;
          dec_nxt   = blk_dec_req;
          ridx_nxt  = blk_dec_req ? IDX_LAST : '0;
        end
      end
      KEXP: begin
        dp_ks_en     = 1'b1;
        dp_round_idx = ridx;
        dp_z_bit     = Z_SEQ[z_ptr];
        z_ptr_nxt    = (z_ptr == 6'd61) ? 6'd0 : z_ptr + 6'd1;
        if (ridx == IDX_LAST) begin
          state_nxt = READY;
          ridx_nxt  = '0;
        end else begin
          ridx_nxt = ridx + RIDX_W'(1);
        end
      end
      RUN: begin
        dp_round_en  = 1'b1;
        dp_round_idx = ridx;
        // Terminal test precedes the step so the index never wraps.
        if (dec ? (ridx == '0) : (ridx == IDX_LAST)) begin
          state_nxt = DONE;
          ridx_nxt  = '0;
        end else begin
          ridx_nxt = dec ? ridx - RIDX_W'(1) : ridx + RIDX_W'(1);
        end
      end
      DONE: begin
        if (blk_out_ready) state_nxt = READY;
      end
      default: state_nxt = NOKEY;
    endcase
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl: expected strobe events are queued per handshake
// and a negedge monitor pops and compares them; a ROUNDS=72 instance covers the z wrap.
module tb_simon_round_ctrl;
  localparam int ROUNDS = 44;
  localparam int RIDX_W = 7;
  localparam int ROUNDS_B = 72;
  localparam logic [61:0] Z3 =
    62'b11_1100001011_0011100101_0001001000_0001111010_0110001101_0111011011;

  typedef enum int {EV_KS, EV_RND, EV_OUT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       zb;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, key_valid = 1'b0, blk_in_valid = 1'b0, blk_out_ready = 1'b0;
  logic key_valid_b = 1'b0, zero = 1'b0;
`ifdef SIMON_DECRYPT_EN
  logic blk_decrypt = 1'b0;
`endif
  logic key_ready, blk_in_ready, blk_out_valid, dp_key_load, dp_ks_en, dp_blk_load;
  logic dp_round_en, dp_z_bit, key_loaded, busy;
  logic [RIDX_W-1:0] dp_round_idx;
  logic key_ready_b, blk_in_ready_b, blk_out_valid_b, dp_key_load_b, dp_ks_en_b, dp_blk_load_b;
  logic dp_round_en_b, dp_z_bit_b, key_loaded_b, busy_b;
  logic [RIDX_W-1:0] dp_round_idx_b;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [61:0] z_ref = Z3;

  simon_round_ctrl #(.ROUNDS(ROUNDS), .RIDX_W(RIDX_W)) u_dut (
    .clk_simon_cfg(clk), .rst_simon_cfg(rst),
    .key_valid(key_valid), .key_ready(key_ready),
    .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
    .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
`ifdef SIMON_DECRYPT_EN
    .blk_decrypt(blk_decrypt),
`endif
    .dp_key_load(dp_key_load), .dp_ks_en(dp_ks_en), .dp_blk_load(dp_blk_load),
    .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx), .dp_z_bit(dp_z_bit),
    .key_loaded(key_loaded), .busy(busy)
  );

  simon_round_ctrl #(.ROUNDS(ROUNDS_B), .RIDX_W(RIDX_W)) u_dut72 (
    .clk_simon_cfg(clk), .rst_simon_cfg(rst),
    .key_valid(key_valid_b), .key_ready(key_ready_b),
    .blk_in_valid(zero), .blk_in_ready(blk_in_ready_b),
    .blk_out_valid(blk_out_valid_b), .blk_out_ready(zero),
`ifdef SIMON_DECRYPT_EN
    .blk_decrypt(zero),
`endif
    .dp_key_load(dp_key_load_b), .dp_ks_en(dp_ks_en_b), .dp_blk_load(dp_blk_load_b),
    .dp_round_en(dp_round_en_b), .dp_round_idx(dp_round_idx_b), .dp_z_bit(dp_z_bit_b),
    .key_loaded(key_loaded_b), .busy(busy_b)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pushKeyEvents();
    for (int k = 4; k < ROUNDS; k++) exp_q.push_back('{EV_KS, k, int'(z_ref[(k - 4) % 62])});
  endtask

  task automatic pushBlockEvents(input bit dec);
    for (int i = 0; i < ROUNDS; i++) exp_q.push_back('{EV_RND, dec ? ROUNDS - 1 - i : i, 0});
    exp_q.push_back('{EV_OUT, 0, 0});
  endtask

  // Monitor: every strobe or output handshake consumes the oldest expected event.
  task automatic runMonitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (dp_ks_en && dp_round_en) checkOutput("strobe_overlap", 1, 0);
      if (dp_ks_en || dp_round_en || (blk_out_valid && blk_out_ready)) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.kind == EV_KS) begin
            checkOutput("ks_en", int'(dp_ks_en), 1);
            checkOutput("ks_idx", int'(dp_round_idx), e.idx);
            checkOutput("ks_z", int'(dp_z_bit), e.zb);
          end else if (e.kind == EV_RND) begin
            checkOutput("round_en", int'(dp_round_en), 1);
            checkOutput("round_idx", int'(dp_round_idx), e.idx);
          end else begin
            checkOutput("out_no_strobe", int'(dp_ks_en | dp_round_en), 0);
          end
        end
      end else begin
        checkOutput("idle_idx", int'(dp_round_idx), 0);
      end
    end
  endtask

  task automatic loadKey(input bit with_blk);
    int cyc;
    key_valid = 1'b1;
    blk_in_valid = with_blk;
    @(negedge clk);
    checkOutput("key_ready", int'(key_ready), 1);
    checkOutput("dp_key_load", int'(dp_key_load), 1);
    checkOutput("blk_in_ready_vs_key", int'(blk_in_ready), 0);
    checkOutput("dp_blk_load_vs_key", int'(dp_blk_load), 0);
    pushKeyEvents();
    tick();
    key_valid = 1'b0;
    if (!with_blk) begin
      cyc = 1;
      forever begin
        @(negedge clk);
        if (key_loaded || cyc >= 200) break;
        cyc++;
        tick();
      end
      checkOutput("key_latency", cyc, ROUNDS - 3);
      tick();
    end
  endtask

  // One block transaction: accept, run, hold in DONE for 'hold' cycles, release.
  task automatic applyStimulus(input bit dec, input int hold);
    int cyc;
    bit dec_eff;
`ifdef SIMON_DECRYPT_EN
    blk_decrypt = dec;
    dec_eff = dec;
`else
    dec_eff = 1'b0;
`endif
    blk_in_valid = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (blk_in_ready || cyc >= 200) break;
      cyc++;
      tick();
    end
    checkOutput("blk_accept", int'(blk_in_ready), 1);
    checkOutput("dp_blk_load", int'(dp_blk_load), 1);
    pushBlockEvents(dec_eff);
    tick();
    blk_in_valid = 1'b0;
`ifdef SIMON_DECRYPT_EN
    blk_decrypt = 1'b0;
`endif
    cyc = 1;
    forever begin
      @(negedge clk);
      if (blk_out_valid || cyc >= 300) break;
      cyc++;
      tick();
    end
    checkOutput("out_latency", cyc, ROUNDS + 1);
    for (int h = 0; h < hold; h++) begin
      tick();
      key_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("hold_valid", int'(blk_out_valid), 1);
      checkOutput("hold_in_ready", int'(blk_in_ready), 0);
      checkOutput("hold_key_ready", int'(key_ready), 0);
      checkOutput("hold_key_ignored", int'(dp_key_load), 0);
      checkOutput("hold_busy", int'(busy), 1);
    end
    tick();
    key_valid = 1'b0;
    blk_out_ready = 1'b1;
    tick();
    blk_out_ready = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_out", int'(blk_in_ready), 1);
    checkOutput("out_dropped", int'(blk_out_valid), 0);
    checkOutput("key_loaded_ready", int'(key_loaded), 1);
    checkOutput("busy_ready", int'(busy), 0);
    tick();
  endtask

  initial begin
    fork
      runMonitor();
    join_none

    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checkOutput("rst_outputs",
                int'({key_ready, blk_in_ready, blk_out_valid, dp_key_load, dp_ks_en,
                      dp_blk_load, dp_round_en, dp_z_bit, key_loaded, busy}), 10'b1000000000);
    checkOutput("rst_idx", int'(dp_round_idx), 0);
    checkOutput("rst_outputs_b",
                int'({key_ready_b, blk_in_ready_b, blk_out_valid_b, dp_key_load_b, dp_ks_en_b,
                      dp_blk_load_b, dp_round_en_b, dp_z_bit_b, key_loaded_b, busy_b}), 10'b1000000000);
    checkOutput("rst_idx_b", int'(dp_round_idx_b), 0);
    tick();
    rst = 1'b0;

    // ROUNDS=72 key schedule: z pointer must wrap back to element 0 at index 66.
    key_valid_b = 1'b1;
    @(negedge clk);
    checkOutput("b_key_load", int'(dp_key_load_b), 1);
    tick();
    key_valid_b = 1'b0;
    for (int k = 4; k < ROUNDS_B; k++) begin
      @(negedge clk);
      checkOutput("b_ks_en", int'(dp_ks_en_b), 1);
      checkOutput("b_ks_idx", int'(dp_round_idx_b), k);
      checkOutput("b_ks_z", int'(dp_z_bit_b), int'(z_ref[(k - 4) % 62]));
      tick();
    end
    @(negedge clk);
    checkOutput("b_key_loaded", int'(key_loaded_b), 1);
    checkOutput("b_ks_done", int'(dp_ks_en_b), 0);
    tick();

    blk_in_valid = 1'b1;
    @(negedge clk);
    checkOutput("nokey_blk_in_ready", int'(blk_in_ready), 0);
    tick();
    blk_in_valid = 1'b0;

    loadKey(1'b0);
    applyStimulus(1'b0, 10);
    loadKey(1'b1);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 3);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          loadKey(1'b1);
          applyStimulus(1'b0, int'($urandom_range(0, 10)));
        end else begin
          loadKey(1'b0);
        end
      end
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)));
    end

    // Reset while round 20 of an encrypt block is on the strobes.
    blk_in_valid = 1'b1;
`ifdef SIMON_DECRYPT_EN
    blk_decrypt = 1'b0;
`endif
    @(negedge clk);
    checkOutput("pre_reset_accept", int'(blk_in_ready), 1);
    pushBlockEvents(1'b0);
    tick();
    blk_in_valid = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rounds_before_reset", exp_q.size(), ROUNDS - 21 + 1);
    exp_q.delete();
    @(negedge clk);
    checkOutput("post_rst_key_loaded", int'(key_loaded), 0);
    checkOutput("post_rst_busy", int'(busy), 0);
    checkOutput("post_rst_key_ready", int'(key_ready), 1);
    checkOutput("post_rst_round_en", int'(dp_round_en), 0);
    tick();
    blk_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_blk_in_ready", int'(blk_in_ready), 0);
      tick();
    end
    loadKey(1'b1);
    applyStimulus(1'b0, 2);

    repeat (3) tick();
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
